// File: rtl/ecc_pkg.sv
// ecc_pkg: shared constants and the SECDED encoder/extractor for the ECC word.
//   DATA_W  data bits per word
//   PAR_W   Hamming parity bits (positions 1, 2, 4, 8, 16)
//   CODE_W  stored bits: overall parity at bit 0, Hamming positions above it
package ecc_pkg;

   localparam int unsigned DATA_W = 20;
   localparam int unsigned PAR_W  = 5;
   localparam int unsigned CODE_W = DATA_W + PAR_W + 1;

   function automatic logic is_par_pos(input int unsigned pos);
      return (pos & (pos - 1)) == 0;
   endfunction

   // Data bits fill the non-power-of-two positions in ascending order. Each
   // Hamming bit then cancels its column of the syndrome, so a clean word
   // always decodes to s = 0; bit 0 makes the whole word even.
   function automatic logic [CODE_W-1:0] ecc_encode(input logic [DATA_W-1:0] data);
      logic [CODE_W-1:0] cw;
      logic [PAR_W-1:0]  syn;
      int unsigned       d;
      cw  = '0;
      syn = '0;
      d   = 0;
      for (int unsigned pos = 1; pos < CODE_W; pos++) begin
         if (!is_par_pos(pos)) begin
            cw[pos] = data[d];
            if (data[d]) syn ^= pos[PAR_W-1:0];
            d++;
         end
      end
      for (int unsigned k = 0; k < PAR_W; k++) begin
         cw[1 << k] = syn[k];
      end
      cw[0] = ^cw;
      return cw;
   endfunction

   function automatic logic [DATA_W-1:0] ecc_extract(input logic [CODE_W-1:0] cw);
      logic [DATA_W-1:0] data;
      int unsigned       d;
      data = '0;
      d    = 0;
      for (int unsigned pos = 1; pos < CODE_W; pos++) begin
         if (!is_par_pos(pos)) begin
            data[d] = cw[pos];
            d++;
         end
      end
      return data;
   endfunction

endpackage

// File: rtl/ecc_secded_decode.sv
// ecc_secded_decode: combinational SECDED decoder.
//   code_i       stored codeword
//   data_o       decoded data (corrected for single errors, raw otherwise)
//   code_corr_o  re-encoded codeword of data_o, used for scrubbing
//   err_o        uncorrectable error
//   corr_o       single-bit error detected and corrected
module ecc_secded_decode
   import ecc_pkg::*;
(
   input  logic [CODE_W-1:0] code_i,
   output logic [DATA_W-1:0] data_o,
   output logic [CODE_W-1:0] code_corr_o,
   output logic              err_o,
   output logic              corr_o
);

   logic [PAR_W-1:0]  syn;
   logic              par;
   logic              in_range;
   logic [CODE_W-1:0] flip;
   logic [CODE_W-1:0] fixed;

   always_comb begin
      syn = '0;
      for (int unsigned pos = 1; pos < CODE_W; pos++) begin
         if (code_i[pos]) syn ^= pos[PAR_W-1:0];
      end
      par      = ^code_i;
      // Syndromes past the last stored position cannot come from one flip.
      in_range = (32'(syn) < CODE_W);
      corr_o   = par && in_range;
      err_o    = (syn != '0 && !par) || (par && !in_range);
      // s = 0 with odd parity means bit 0 itself flipped; data is untouched.
      flip     = '0;
      if (corr_o && syn != '0) flip = {{(CODE_W-1){1'b0}}, 1'b1} << syn;
      fixed       = code_i ^ flip;
      data_o      = ecc_extract(fixed);
      code_corr_o = ecc_encode(data_o);
   end

endmodule

// File: rtl/ecc_mem_word.sv
// ecc_mem_word: one SECDED-protected storage word with write and scrub.
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset, clears the stored codeword
//   WE     write enable
//   in     write data
//   out    decoded (corrected when possible) stored data
//   err    uncorrectable error in the stored word
//   corr   single-bit error corrected on out; scrubbed on the next idle edge
module ecc_mem_word #(
   // Must match ecc_pkg::DATA_W; the encoder is sized by the package.
   parameter int unsigned DATA_W = ecc_pkg::DATA_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              WE,
   input  logic [DATA_W-1:0] in,
   output logic [DATA_W-1:0] out,
   output logic              err,
   output logic              corr
);
   import ecc_pkg::*;

   logic [CODE_W-1:0] code;
   logic [CODE_W-1:0] code_d;
   logic [CODE_W-1:0] code_corr;

   ecc_secded_decode u_dec (
      .code_i      (code),
      .data_o      (out),
      .code_corr_o (code_corr),
      .err_o       (err),
      .corr_o      (corr)
   );

   // A write always wins; otherwise a correctable word is rewritten clean.
   // Uncorrectable words are held as-is until the next write.
   always_comb begin
      code_d = code;
      if (WE) begin
         code_d = ecc_encode(in);
      end else if (corr) begin
         code_d = code_corr;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         code <= '0;
      end else begin
         code <= code_d;
      end
   end

endmodule

// File: tb/tb_ecc_mem_word.sv
// tb_ecc_mem_word: scoreboard bench for ecc_mem_word. Stimulus pushes the
// expected response into a queue; a monitor pops and compares it.
module tb_ecc_mem_word;

   logic        clk;
   logic        rst_n;
   logic        WE;
   logic [19:0] in;
   logic [19:0] out;
   logic        err;
   logic        corr;

   int checks = 0;
   int errors = 0;

   typedef struct {
      string       name;
      logic [19:0] out;
      logic        err;
      logic        corr;
      bit          chk_code;
      logic [25:0] code;
   } exp_t;

   exp_t exp_q[$];
   event chk_ev;

   logic [19:0] model;
   logic [25:0] fv;

   ecc_mem_word dut (
      .clk   (clk),
      .rst_n (rst_n),
      .WE    (WE),
      .in    (in),
      .out   (out),
      .err   (err),
      .corr  (corr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: timeout reached, expected $finish first");
      $fatal(1, "timeout");
   end

   // Reference encoding: data in non-power-of-two positions; Hamming bit 2^k
   // is the parity of data positions with bit k set; bit 0 evens the word.
   function automatic logic [25:0] model_encode(input logic [19:0] d);
      logic [25:0] cw;
      int          di;
      cw = '0;
      di = 0;
      for (int pos = 3; pos < 26; pos++) begin
         if (pos != 4 && pos != 8 && pos != 16) begin
            cw[pos] = d[di];
            di++;
         end
      end
      for (int k = 0; k < 5; k++) begin
         logic b;
         b = 1'b0;
         for (int pos = 3; pos < 26; pos++) begin
            if (((pos >> k) & 1) == 1) b ^= cw[pos];
         end
         cw[1 << k] = b;
      end
      cw[0] = ^cw;
      return cw;
   endfunction

   // Monitor: compares every pending expectation against the DUT outputs.
   initial begin
      forever begin
         @(chk_ev);
         while (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            checks++;
            if (out !== e.out) begin
               errors++;
               $display("FAIL %s out: got %h want %h", e.name, out, e.out);
            end
            checks++;
            if (err !== e.err) begin
               errors++;
               $display("FAIL %s err: got %b want %b", e.name, err, e.err);
            end
            checks++;
            if (corr !== e.corr) begin
               errors++;
               $display("FAIL %s corr: got %b want %b", e.name, corr, e.corr);
            end
            if (e.chk_code) begin
               checks++;
               if (dut.code !== e.code) begin
                  errors++;
                  $display("FAIL %s code: got %h want %h", e.name, dut.code, e.code);
               end
            end
         end
      end
   end

   task automatic expect_now(input string name, input logic [19:0] o, input logic e,
                             input logic c, input bit cc, input logic [25:0] cw);
      exp_t x;
      x.name = name; x.out = o; x.err = e; x.corr = c; x.chk_code = cc; x.code = cw;
      exp_q.push_back(x);
      -> chk_ev;
      #1;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [19:0] d);
      WE = 1'b1;
      in = d;
      step();
      WE = 1'b0;
      model = d;
   endtask

   task automatic flip(input logic [25:0] mask);
      fv = dut.code ^ mask;
      force dut.code = fv;
      #1;
      release dut.code;
   endtask

   task automatic single_err(input string name, input logic [19:0] d, input int pos);
      wr(d);
      flip(26'd1 << pos);
      expect_now({name, "_corr"}, d, 1'b0, 1'b1, 1'b0, '0);
      step();
      expect_now({name, "_scrub"}, d, 1'b0, 1'b0, 1'b1, model_encode(d));
   endtask

   initial begin
      rst_n = 1'b0;
      WE    = 1'b0;
      in    = '0;
      model = '0;
      #1;
      expect_now("reset", 20'h0, 1'b0, 1'b0, 1'b1, 26'h0);
      #10;
      rst_n = 1'b1;
      step();

      wr(20'hABCDE);
      expect_now("write", 20'hABCDE, 1'b0, 1'b0, 1'b1, model_encode(20'hABCDE));
      in = 20'h12345;
      for (int i = 0; i < 3; i++) begin
         step();
         expect_now("hold", 20'hABCDE, 1'b0, 1'b0, 1'b1, model_encode(20'hABCDE));
      end

      single_err("pos7", 20'hABCDE, 7);
      single_err("pos0", 20'hABCDE, 0);
      single_err("pos16", 20'hABCDE, 16);

      wr(20'h0F0F0);
      flip((26'd1 << 3) | (26'd1 << 5));
      expect_now("dbl", 20'h0F0F3, 1'b1, 1'b0, 1'b0, '0);
      for (int i = 0; i < 2; i++) begin
         step();
         expect_now("dbl_hold", 20'h0F0F3, 1'b1, 1'b0, 1'b1,
                    model_encode(20'h0F0F0) ^ 26'h28);
      end
      wr(20'h00001);
      expect_now("dbl_rewrite", 20'h00001, 1'b0, 1'b0, 1'b1, model_encode(20'h00001));

      for (int p = 0; p < 26; p++) begin
         single_err($sformatf("sweep%0d", p), 20'h5A5A5, p);
      end

      wr(20'hFFFFF);
      expect_now("pre_rst", 20'hFFFFF, 1'b0, 1'b0, 1'b1, model_encode(20'hFFFFF));
      rst_n = 1'b0;
      model = '0;
      #1;
      expect_now("async_rst", 20'h0, 1'b0, 1'b0, 1'b1, 26'h0);
      step();
      expect_now("rst_held", 20'h0, 1'b0, 1'b0, 1'b1, 26'h0);
      #2;
      rst_n = 1'b1;
      step();
      expect_now("post_rst", 20'h0, 1'b0, 1'b0, 1'b1, 26'h0);

      for (int i = 0; i < 25; i++) begin
         WE = 1'($urandom_range(0, 1));
         in = 20'($urandom);
         step();
         if (WE) model = in;
         WE = 1'b0;
         expect_now($sformatf("rand%0d", i), model, 1'b0, 1'b0, 1'b1, model_encode(model));
      end

      #5;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d pending want 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ecc_mem_word.md
Name: ecc_mem_word

Overview:
Single 20-bit storage word protected by a Hamming SECDED code (20 data, 5 Hamming parity and 1 overall parity bit, 26 bits stored). Data is encoded on write and decoded combinationally on read. Single-bit errors are corrected, and scrubbed back into storage on the next idle clock. Double-bit errors are flagged on err. It is the building block replicated to form the ECC-protected memory array.

Parameters:
- DATA_W, default 20: data width.
  - Derived localparams (not overridable): PAR_W = 5 Hamming bits; CODE_W = DATA_W + PAR_W + 1 = 26.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- WE  input  1  write enable, sampled on rising clk.
- in  input  DATA_W  write data.
- out  output  DATA_W  decoded (corrected when possible) stored data.
- err  output  1  uncorrectable (double-bit) error detected in stored word.
- corr  output  1  single-bit error detected and corrected on out.

Behaviour:
- Storage: one CODE_W-bit register named code. Bit 0 is overall parity; bits 1..25 are Hamming positions 1..25.
- Codeword layout:
  - Hamming parity bits sit at positions 1, 2, 4, 8, 16.
  - Data bits fill the remaining positions in ascending order: in[0] at 3, in[1] at 5, in[2] at 6, in[3] at 7, in[4] at 9, … in[19] at 25.
  - Parity bit at position 2^k is the XOR of all data positions whose index has bit k set.
  - Bit 0 makes the XOR of all 26 bits even.
  - encode(0) = 0.
- Reset: rst_n low clears code to 0 asynchronously. While in reset: out=0, err=0, corr=0.
- Write: on rising clk with WE=1, code <= encode(in). out reflects the new data immediately after the edge (zero-cycle read latency, no read latency stage).
- Hold: with WE=0 and no correctable error, code is unchanged; changes on in have no effect.
- Decode (combinational from code):
  - s = XOR of indices of all set bits in positions 1..25 (5 bits).
  - p = XOR of all 26 bits.
- Decode cases:
  - s=0, p=0: clean. out = data bits, err=0, corr=0.
  - s≠0, p=1, s≤25: single error at position s. out = data with that position flipped, corr=1, err=0.
  - s=0, p=1: overall-parity bit error. out = data bits, corr=1, err=0.
  - s≠0, p=0: double error. out = raw uncorrected data bits, err=1, corr=0.
  - s>25 with p=1: treated as uncorrectable. err=1, corr=0, out = raw data.
- Scrub: on rising clk with WE=0 and corr=1, code <= corrected codeword (recomputed encode(out)). The next cycle shows corr=0.
- Priority: WE=1 overrides scrub, and a write always replaces a faulty word. With err=1 and WE=0, code is held (no scrub).
- No X propagation from in when WE=0.

Decomposition:
- Shared package ecc_pkg: DATA_W, PAR_W, CODE_W constants and a pure function ecc_encode(data) -> codeword.
- One sub-module, ecc_secded_decode: input codeword; outputs data, corrected codeword, err, corr. Purely combinational.
- Top ecc_mem_word holds the register, the write/scrub mux and the reset.

Test Plan:
- Reset: rst_n=0 mid-run after writing 20'hFFFFF -> out=0, err=0, corr=0 immediately, without waiting for a clock.
- Write/hold: WE=1, in=20'hABCDE, one edge -> out=20'hABCDE, err=0, corr=0. Then WE=0, in=20'h12345 for 3 edges -> out stays 20'hABCDE.
- Single-error correction and scrub:
  - After storing 20'hABCDE, force code[7] inverted and release -> out=20'hABCDE, corr=1, err=0.
  - Next edge with WE=0 -> code = encode(20'hABCDE), corr=0.
  - Repeat with code[0] and code[16] (parity bits) -> same result.
- Double error: after storing 20'h0F0F0, invert code[3] and code[5] -> err=1, corr=0, out = raw data with bits 0 and 1 flipped (20'h0F0F3). Code is unchanged over 2 idle edges. A write of 20'h00001 clears err.
- Exhaustive single-bit sweep: for each of the 26 positions, on stored 20'h5A5A5 -> out=20'h5A5A5, corr=1.
- Random: 25 cycles of random WE/in, compared against a reference model (last written value, 0 after reset) -> out matches, err=0, corr=0 throughout.
